// File: rtl/pipe_fetch_ctrl_pkg.sv
// Shared constants and types for the fetch-stage sequencer.
//  ADDR_W     : instruction address width
//  CNT_W      : default stall counter width
//  RESET_PC   : pc value held during reset / BOOT
//  EXC_VECTOR : exception entry address
//  state_t    : fetch FSM states ST_BOOT/ST_RUN/ST_WAIT/ST_PEND
package pipe_fetch_ctrl_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 16;

   localparam logic [ADDR_W-1:0] RESET_PC   = 32'hFFFF_FFFC;
   localparam logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0008;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2,
      ST_PEND = 2'd3
   } state_t;

endpackage

// File: rtl/pipe_fetch_ctrl_pc_next_mux.sv
// Priority select of the redirect target: exception > eret > branch.
//  exc_req, eret_req, br_taken, hazard_stall : request inputs
//  br_target, epc                            : candidate addresses
//  redirect_c                                : some redirect source won
//  target_c                                  : word-aligned redirect address
//  misalign_c                                : winning branch target had low bits set
module pipe_fetch_ctrl_pc_next_mux
   import pipe_fetch_ctrl_pkg::*;
#(
   parameter logic [ADDR_W-1:0] EXC_VECTOR = pipe_fetch_ctrl_pkg::EXC_VECTOR
) (
   input  logic              exc_req,
   input  logic              eret_req,
   input  logic              br_taken,
   input  logic              hazard_stall,
   input  logic [ADDR_W-1:0] br_target,
   input  logic [ADDR_W-1:0] epc,
   output logic              redirect_c,
   output logic [ADDR_W-1:0] target_c,
   output logic              misalign_c
);

   // A branch under a load-use stall is not resolved yet, so it cannot win.
   always_comb begin
      redirect_c = 1'b0;
      target_c   = '0;
      misalign_c = 1'b0;
      if (exc_req) begin
         redirect_c = 1'b1;
         target_c   = EXC_VECTOR;
      end else if (eret_req) begin
         redirect_c = 1'b1;
         target_c   = epc;
      end else if (br_taken && !hazard_stall) begin
         redirect_c = 1'b1;
         target_c   = {br_target[ADDR_W-1:2], 2'b00};
         misalign_c = |br_target[1:0];
      end
   end

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage sequencer: owns pc, picks sequential/redirect/exception/eret
// next address, drives IF/ID write/flush and holds on hazards and imem waits.
//  clock, reset   : clock, synchronous active-high reset
//  imem_ready     : imem returns data for pc this cycle
//  hazard_stall   : load-use stall from ID
//  br_taken/br_target, exc_req, eret_req : redirect requests
//  pc, epc        : fetch address, saved exception pc (registered)
//  fetch_valid    : pc is a real fetch (registered)
//  ifid_write, ifid_flush, misalign : combinational controls
//  stall_cnt      : saturating count of non-writing RUN/WAIT cycles
module pipe_fetch_ctrl
   import pipe_fetch_ctrl_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = pipe_fetch_ctrl_pkg::RESET_PC,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = pipe_fetch_ctrl_pkg::EXC_VECTOR,
   parameter int unsigned       CNT_W      = pipe_fetch_ctrl_pkg::CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              imem_ready,
   input  logic              hazard_stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              exc_req,
   input  logic              eret_req,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_valid,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic [ADDR_W-1:0] epc,
   output logic              misalign,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_nxt, epc_nxt, pend_pc, pend_pc_nxt, pend_tgt;
   logic              pend_exc, pend_exc_nxt, fetch_valid_nxt, cnt_inc;
   logic              mux_redirect, mux_misalign;
   logic [ADDR_W-1:0] mux_target;

   pipe_fetch_ctrl_pc_next_mux #(.EXC_VECTOR(EXC_VECTOR)) u_pc_next_mux (
      .exc_req      (exc_req),
      .eret_req     (eret_req),
      .br_taken     (br_taken),
      .hazard_stall (hazard_stall),
      .br_target    (br_target),
      .epc          (epc),
      .redirect_c   (mux_redirect),
      .target_c     (mux_target),
      .misalign_c   (mux_misalign)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= ST_BOOT;
      else       state <= state_nxt;
   end

   // Next state, next datapath values and combinational controls.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      epc_nxt         = epc;
      pend_pc_nxt     = pend_pc;
      pend_exc_nxt    = pend_exc;
      pend_tgt        = pend_pc;
      fetch_valid_nxt = fetch_valid;
      ifid_write      = 1'b0;
      ifid_flush      = 1'b0;
      misalign        = 1'b0;
      cnt_inc         = 1'b0;
      if (!reset) begin
         unique case (state)
            ST_BOOT: begin
               pc_nxt          = RESET_PC + 32'd4;
               fetch_valid_nxt = 1'b1;
               state_nxt       = ST_RUN;
            end
            ST_RUN, ST_WAIT: begin
               misalign = mux_misalign;
               if (exc_req) epc_nxt = pc;
               if (mux_redirect && imem_ready) begin
                  pc_nxt     = mux_target;
                  ifid_write = 1'b1;
                  ifid_flush = 1'b1;
                  state_nxt  = ST_RUN;
               end else if (mux_redirect) begin
                  pend_pc_nxt  = mux_target;
                  pend_exc_nxt = exc_req;
                  state_nxt    = ST_PEND;
               end else if (imem_ready && !hazard_stall) begin
                  pc_nxt     = pc + 32'd4;
                  ifid_write = 1'b1;
                  state_nxt  = ST_RUN;
               end else begin
                  state_nxt = imem_ready ? ST_RUN : ST_WAIT;
               end
               cnt_inc = !ifid_write;
            end
            ST_PEND: begin
               // Only a newer exception can displace the pending target.
               pend_tgt = exc_req ? EXC_VECTOR : pend_pc;
               if (exc_req && !pend_exc) epc_nxt = pc;
               if (imem_ready) begin
                  pc_nxt       = pend_tgt;
                  ifid_write   = 1'b1;
                  ifid_flush   = 1'b1;
                  pend_exc_nxt = 1'b0;
                  state_nxt    = ST_RUN;
               end else begin
                  pend_pc_nxt  = pend_tgt;
                  pend_exc_nxt = pend_exc | exc_req;
               end
            end
            default: state_nxt = ST_BOOT;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc          <= RESET_PC;
         epc         <= '0;
         pend_pc     <= '0;
         pend_exc    <= 1'b0;
         fetch_valid <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         pc          <= pc_nxt;
         epc         <= epc_nxt;
         pend_pc     <= pend_pc_nxt;
         pend_exc    <= pend_exc_nxt;
         fetch_valid <= fetch_valid_nxt;
         if (cnt_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Bench for pipe_fetch_ctrl: directed scenarios plus random traffic against
// a flag-based behavioural model of the fetch sequencer.
module tb_pipe_fetch_ctrl;

   localparam int unsigned CNT_W   = 16;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [31:0] RST_PC  = 32'hFFFF_FFFC;
   localparam logic [31:0] EXC_V   = 32'h0000_0008;

   logic             clock = 1'b0;
   logic             reset, imem_ready, hazard_stall, br_taken, exc_req, eret_req;
   logic [31:0]      br_target;
   logic [31:0]      pc, epc;
   logic             fetch_valid, ifid_write, ifid_flush, misalign;
   logic [CNT_W-1:0] stall_cnt;

   pipe_fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_V), .CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .imem_ready   (imem_ready),
      .hazard_stall (hazard_stall),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .exc_req      (exc_req),
      .eret_req     (eret_req),
      .pc           (pc),
      .fetch_valid  (fetch_valid),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .epc          (epc),
      .misalign     (misalign),
      .stall_cnt    (stall_cnt)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: booting / pending flags rather than a state encoding.
   bit          m_boot, m_pend, m_pend_exc;
   logic [31:0] m_pc, m_epc, m_pend_pc;
   int          m_cnt;
   bit          e_wr, e_fl, e_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit rst, rdy, hz, br, input logic [31:0] bt,
                             input bit exc, eret);
      bit          redir;
      logic [31:0] tgt;
      e_wr = 0; e_fl = 0; e_mis = 0;
      if (rst) begin
         m_pc = RST_PC; m_epc = 0; m_cnt = 0; m_boot = 1;
         m_pend = 0; m_pend_pc = 0; m_pend_exc = 0;
         return;
      end
      if (m_boot) begin
         m_pc = RST_PC + 32'd4; m_boot = 0;
         return;
      end
      if (m_pend) begin
         tgt = exc ? EXC_V : m_pend_pc;
         if (exc && !m_pend_exc) m_epc = m_pc;
         if (rdy) begin
            e_wr = 1; e_fl = 1; m_pc = tgt; m_pend = 0; m_pend_exc = 0;
         end else begin
            m_pend_pc = tgt; m_pend_exc = m_pend_exc | exc;
         end
         return;
      end
      redir = exc || eret || (br && !hz);
      tgt   = exc ? EXC_V : (eret ? m_epc : {bt[31:2], 2'b00});
      e_mis = !exc && !eret && br && !hz && (bt[1:0] != 2'b00);
      if (exc) m_epc = m_pc;
      if (redir && rdy) begin
         e_wr = 1; e_fl = 1; m_pc = tgt;
      end else if (redir) begin
         m_pend = 1; m_pend_pc = tgt; m_pend_exc = exc;
      end else if (rdy && !hz) begin
         e_wr = 1; m_pc = m_pc + 32'd4;
      end
      if (!e_wr && m_cnt < CNT_MAX) m_cnt++;
   endtask

   // One clock: drive, check combinational controls, clock, check registers.
   task automatic step(input bit rst, rdy, hz, br, input logic [31:0] bt,
                       input bit exc, eret);
      reset = rst; imem_ready = rdy; hazard_stall = hz; br_taken = br;
      br_target = bt; exc_req = exc; eret_req = eret;
      #2;
      model_step(rst, rdy, hz, br, bt, exc, eret);
      chk("ifid_write", 32'(ifid_write), 32'(e_wr));
      chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
      chk("misalign",   32'(misalign),   32'(e_mis));
      @(posedge clock);
      #1;
      chk("pc",          pc,              m_pc);
      chk("epc",         epc,             m_epc);
      chk("stall_cnt",   32'(stall_cnt),  32'(m_cnt));
      chk("fetch_valid", 32'(fetch_valid), 32'(!m_boot));
   endtask

   initial begin
      // 1: reset, BOOT, sequential fetch from 0
      repeat (3) step(1, 1, 0, 0, 0, 0, 0);
      chk("rst_pc", pc, 32'hFFFF_FFFC);
      chk("rst_fv", 32'(fetch_valid), 32'd0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("boot_pc", pc, 32'h0);
      step(0, 1, 0, 0, 0, 0, 0);  chk("seq_pc4", pc, 32'h4);
      step(0, 1, 0, 0, 0, 0, 0);  chk("seq_pc8", pc, 32'h8);
      step(0, 1, 0, 0, 0, 0, 0);  chk("seq_pcC", pc, 32'hC);

      // 2: hazard stall suppresses branch
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 32'h80, 0, 0);
      step(0, 1, 1, 1, 32'h80, 0, 0);
      chk("hz_pc", pc, 32'h10);
      chk("hz_cnt", 32'(stall_cnt), 32'd2);
      step(0, 1, 0, 0, 0, 0, 0);  chk("hz_rel_pc", pc, 32'h14);

      // 3: branch while imem waits goes pending, applied when ready
      repeat (3) step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h100, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("pend_pc_hold", pc, 32'h20);
      step(0, 1, 0, 0, 0, 0, 0);  chk("pend_apply", pc, 32'h100);
      step(0, 1, 0, 0, 0, 0, 0);

      // 4: exception beats branch, eret returns
      step(0, 1, 0, 1, 32'h40, 0, 0);
      step(0, 1, 0, 1, 32'h300, 1, 0);
      chk("exc_pc", pc, 32'h8);
      chk("exc_epc", epc, 32'h40);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1);  chk("eret_pc", pc, 32'h40);

      // 5: misaligned target, pc wrap
      step(0, 1, 0, 1, 32'h203, 0, 0);
      chk("mis_pc", pc, 32'h200);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);  chk("wrap_pc", pc, 32'h0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom,
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      end

      // 6: reset while pending drops the target; counter saturation
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h500, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("rp_pc", pc, 32'hFFFF_FFFC);
      chk("rp_fv", 32'(fetch_valid), 32'd0);
      step(0, 1, 0, 0, 0, 0, 0);  chk("rp_boot_pc", pc, 32'h0);
      step(0, 1, 0, 0, 0, 0, 0);  chk("rp_lost_pc", pc, 32'h4);

      reset = 0; imem_ready = 1; hazard_stall = 1; br_taken = 0;
      exc_req = 0; eret_req = 0;
      repeat (CNT_MAX + 5) @(posedge clock);
      #1;
      m_cnt = CNT_MAX;
      chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
      chk("sat_pc", pc, 32'h4);
      step(0, 1, 1, 0, 0, 0, 0);
      chk("sat_stick", 32'(stall_cnt), 32'h0000_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
